dmem_arbiter: RTL

Two-requester controller that shares the 16-bit-wide data memory between the CPU load/store port (m0) and a DMA/loader port (m1). It arbitrates round-robin and converts each 32-bit request into two sequenced half-word memory beats (low, then high), returning a registered 32-bit read result and a one-cycle acknowledge. It sits between the datapath's memory stage and the data memory's addr/write_data/write_en/read/read_data pins.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Both the top level and the round-robin arbiter import this package.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam int unsigned MEM_W       = 16;
  localparam int unsigned HALF_OFFSET = 2;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the port that did not own the previous transaction wins.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && req_i[1]) begin
      if (last_owner_i == PORT_M1) begin
        grant_o = 2'b01;
      end else begin
        grant_o = 2'b10;
      end
    end else if (req_i[0]) begin
      grant_o = 2'b01;
    end else if (req_i[1]) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a 16-bit data memory between the CPU (m0) and DMA (m1) ports,
// splitting each 32-bit request into a low beat followed by a high beat.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [MEM_W-1:0]  mem_write_data_o,
  output logic              mem_write_en_o,
  output logic              mem_read_o,
  input  logic [MEM_W-1:0]  mem_read_data_i,

  output logic              busy_o,
  output logic              owner_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e              state_q, state_d;
  logic                owner_q, last_owner_q, we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MEM_W-1:0]    lo_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;

  logic [1:0]          grant;
  logic                start;
  logic                sel_port;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_base;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter2 u_rr (
    .req_i        ({m1_req_i, m0_req_i}),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  // Winner's fields are only consulted when leaving IDLE.
  always_comb begin
    start     = (state_q == IDLE) && (m0_req_i || m1_req_i);
    sel_port  = grant[1] ? PORT_M1 : PORT_M0;
    sel_we    = grant[1] ? m1_we_i : m0_we_i;
    sel_base  = (grant[1] ? m1_addr_i : m0_addr_i) & ALIGN_MASK;
    sel_wdata = grant[1] ? m1_wdata_i : m0_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= PORT_M0;
      last_owner_q <= PORT_M1;
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
    end else if (start) begin
      owner_q      <= sel_port;
      last_owner_q <= sel_port;
      we_q         <= sel_we;
      base_q       <= sel_base;
      wdata_q      <= sel_wdata;
    end
  end

  // The low half is parked until the high beat completes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
    end else if (state_q == LO && !we_q) begin
      lo_q <= mem_read_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (state_q == HI && !we_q) begin
      if (owner_q == PORT_M0) begin
        m0_rdata_q <= {mem_read_data_i, lo_q};
      end else begin
        m1_rdata_q <= {mem_read_data_i, lo_q};
      end
    end
  end

  always_comb begin
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_write_en_o   = 1'b0;
    mem_read_o       = 1'b0;
    m0_ack_o         = 1'b0;
    m1_ack_o         = 1'b0;
    unique case (state_q)
      LO: begin
        mem_addr_o       = base_q;
        mem_write_data_o = wdata_q[MEM_W-1:0];
        mem_write_en_o   = we_q;
        mem_read_o       = ~we_q;
      end
      HI: begin
        mem_addr_o       = base_q + ADDR_W'(HALF_OFFSET);
        mem_write_data_o = wdata_q[DATA_W-1:MEM_W];
        mem_write_en_o   = we_q;
        mem_read_o       = ~we_q;
      end
      ACK: begin
        m0_ack_o = (owner_q == PORT_M0);
        m1_ack_o = (owner_q == PORT_M1);
      end
      default: ;
    endcase
  end

  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;
  assign busy_o     = (state_q != IDLE);
  assign owner_o    = owner_q;

endmodule
